// File: rtl/alu_cmd_sequencer.sv
// Narrow-bus command/operand loader and result capture around a wide ALU.
// Optional result chaining is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_cmd_sequencer #(
  parameter int DWIDTH = 128,
  parameter int BWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BWIDTH-1:0] in_data,
  output logic [DWIDTH-1:0] op1,
  output logic [DWIDTH-1:0] op2,
  output logic [2:0]        opsel,
  output logic              mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag,
  output logic              busy
);

  localparam int WORDS = DWIDTH / BWIDTH;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    CMD, LOAD_A, LOAD_B, EXEC, HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_fire;
  logic          last;
  logic          unused;

  assign in_ready = (state == CMD) || (state == LOAD_A)
                 || (state == LOAD_B);
  assign busy     = (state != CMD);
  assign in_fire  = in_valid && in_ready;
  assign last     = (cnt == CW'(WORDS - 1));
  assign unused   = ^in_data;

`ifdef ALU_SEQ_CHAIN_EN
  logic chain_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_ok <= 1'b0;
    end else if (out_valid && out_ready) begin
      chain_ok <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CMD;
      cnt       <= '0;
      op1       <= '0;
      op2       <= '0;
      opsel     <= '0;
      mode      <= 1'b0;
      result    <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      o_flag    <= 1'b0;
      s_flag    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        CMD: begin
          if (in_fire) begin
            opsel <= in_data[2:0];
            mode  <= in_data[3];
            cnt   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            if (in_data[4] && chain_ok) begin
              op1   <= result;
              state <= LOAD_B;
            end else begin
              state <= LOAD_A;
            end
`else
            state <= LOAD_A;
`endif
          end
        end
        LOAD_A: begin
          if (in_fire) begin
            op1[cnt*BWIDTH +: BWIDTH] <= in_data;
            if (last) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            op2[cnt*BWIDTH +: BWIDTH] <= in_data;
            if (last) begin
              cnt   <= '0;
              state <= EXEC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          // operands were stable for a full cycle; ALU output has settled
          result    <= alu_result;
          c_flag    <= alu_c;
          z_flag    <= alu_z;
          o_flag    <= alu_o;
          s_flag    <= alu_s;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= CMD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          cnt       <= '0;
          state     <= CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a stub ALU driven by the bench.
// Expected chaining behaviour follows ALU_SEQ_CHAIN_EN.
module tb_alu_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [127:0] op1, op2;
  logic [2:0]   opsel;
  logic         mode;
  logic [127:0] alu_result = '0;
  logic         alu_c = 1'b0, alu_z = 1'b0;
  logic         alu_o = 1'b0, alu_s = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] result;
  logic         c_flag, z_flag, o_flag, s_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
    .alu_result(alu_result),
    .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o), .alu_s(alu_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
    .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word transfers.
  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_tmo", 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] cmd,
                      input logic [127:0] a,
                      input logic [127:0] b,
                      input int maxgap);
    send_word(cmd, 0);
    for (int k = 0; k < 4; k++)
      send_word(a[k*32 +: 32], maxgap ? $urandom_range(maxgap) : 0);
    for (int k = 0; k < 4; k++)
      send_word(b[k*32 +: 32], maxgap ? $urandom_range(maxgap) : 0);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_tmo", out_valid, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_ov", out_valid, 1'b0);
  endtask

  logic [127:0] opa, opb, exp1, exp2;
  logic [31:0]  words [9];
  int           k, n;
  logic         fire;

  initial begin
    // reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ir", in_ready, 1'b1);
    check("rst_ov", out_valid, 1'b0);
    check("rst_res", result, '0);
    check("rst_flg", {c_flag, z_flag, o_flag, s_flag}, 4'b0);
    check("rst_busy", busy, 1'b0);

    // basic op, no stalls
    alu_result = 128'hDEADBEEF;
    alu_c = 1'b1;
    alu_z = 1'b0;
    opa = {32'h4, 32'h3, 32'h2, 32'h1};
    opb = {32'h8, 32'h7, 32'h6, 32'h5};
    load(32'h0000000A, opa, opb, 0);
    check("exec_ov", out_valid, 1'b0);
    check("exec_ir", in_ready, 1'b0);
    check("op1", op1, opa);
    check("op2", op2, opb);
    check("opsel", opsel, 3'd2);
    check("mode", mode, 1'b1);
    @(negedge clk);
    check("lat_ov", out_valid, 1'b1);
    check("res", result, 128'hDEADBEEF);
    check("cflag", c_flag, 1'b1);
    check("zflag", z_flag, 1'b0);

    // backpressure: ALU output moves, captured result must not
    alu_result = 128'h1234;
    alu_c = 1'b0;
    alu_z = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_res", result, 128'hDEADBEEF);
      check("hold_c", c_flag, 1'b1);
      check("hold_ir", in_ready, 1'b0);
      check("hold_ov", out_valid, 1'b1);
    end

    // transfer with in_valid high: command only on the following edge
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("xfer_ov", out_valid, 1'b0);
    check("xfer_busy", busy, 1'b0);
    check("xfer_opsel", opsel, 3'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("next_busy", busy, 1'b1);
    check("next_opsel", opsel, 3'd5);
    check("next_mode", mode, 1'b0);

    // random input gaps while loading
    opa = {32'hA3A3A3A3, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h11111111};
    opb = {32'h80000000, 32'h00000001, 32'hCAFEF00D, 32'h76543210};
    alu_result = 128'h55;
    alu_o = 1'b1;
    alu_s = 1'b1;
    for (int i = 0; i < 4; i++)
      send_word(opa[i*32 +: 32], $urandom_range(3));
    for (int i = 0; i < 4; i++)
      send_word(opb[i*32 +: 32], $urandom_range(3));
    check("gap_op1", op1, opa);
    check("gap_op2", op2, opb);
    wait_out();
    check("gap_res", result, 128'h55);
    check("gap_os", {o_flag, s_flag}, 2'b11);
    drain();

    // reset after 3 op1 words
    send_word(32'h3, 0);
    for (int i = 0; i < 3; i++) send_word(32'h99 + i, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_op1", op1, '0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_ir", in_ready, 1'b1);
    check("mrst_ov", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    alu_result = 128'h77;
    load(32'h4, opa, opb, 0);
    check("post_op1", op1, opa);
    check("post_op2", op2, opb);
    check("post_opsel", opsel, 3'd4);
    wait_out();
    check("post_res", result, 128'h77);
    drain();

    // chaining: first op yields 0x10, then command 0x1A
    alu_result = 128'h10;
    load(32'h2, opa, opb, 0);
    wait_out();
    drain();
    words[0] = 32'h1A;
    for (int i = 1; i < 9; i++) words[i] = 32'h4 + i;
    k = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = (k < 9);
      in_data  = words[(k < 9) ? k : 0];
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) k++;
      n++;
    end
    in_valid = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    exp1 = 128'h10;
    exp2 = {32'h8, 32'h7, 32'h6, 32'h5};
    check("chain_words", k, 5);
`else
    exp1 = {32'h8, 32'h7, 32'h6, 32'h5};
    exp2 = {32'hC, 32'hB, 32'hA, 32'h9};
    check("chain_words", k, 9);
`endif
    check("chain_ov", out_valid, 1'b1);
    check("chain_op1", op1, exp1);
    check("chain_op2", op2, exp2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
